// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Accepts the registered execute result, performs loads and stores against
// the data memory over a req/ack handshake, stalls execute while an access
// is outstanding, and registers the values writeback consumes.
//
// Optional feature macro: MEM_ALIGN_CHECK_EN
//   defined   : memory ops with address[1:0] != 0 are rejected and
//               mem_exc_misalign pulses for one cycle.
//   undefined : address[1:0] ignored, mem_exc_misalign tied 0.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   exe_mem_*             instruction from execute (ignored while stalled)
//   dmem_mem_rdata/ack    data memory response
//   mem_dmem_*            data memory request (driven from registered state)
//   mem_stall             execute must hold its outputs
//   mem_exc_misalign      misaligned-access pulse
//   mem_wb_*              registered writeback values
//
// state | meaning
// IDLE  | ready to accept an instruction from execute
// REQ   | memory access outstanding, waiting for ack
module mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exe_mem_valid,
  input  logic [31:0] exe_mem_reslt_data,
  input  logic [31:0] exe_mem_store_data,
  input  logic        exe_mem_rd_en,
  input  logic        exe_mem_wr_en,
  input  logic        exe_mem_reg_wr_en,
  input  logic [4:0]  exe_mem_reg_wr_add,
  input  logic [31:0] dmem_mem_rdata,
  input  logic        dmem_mem_ack,
  output logic        mem_dmem_req,
  output logic        mem_dmem_we,
  output logic [31:0] mem_dmem_addr,
  output logic [31:0] mem_dmem_wdata,
  output logic        mem_stall,
  output logic        mem_exc_misalign,
  output logic [31:0] mem_wb_memory_data,
  output logic [31:0] mem_wb_reg_wr_data,
  output logic        mem_wb_reg_wr_en,
  output logic        mem_wb_rm_data_sel,
  output logic [4:0]  mem_wb_reg_wr_add
);

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:2] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        reg_wr_en_q;
  logic        is_mem;
  logic        is_store;
  logic        misalign;
  logic        accept;

  always_comb begin
    is_mem   = exe_mem_rd_en | exe_mem_wr_en;
    is_store = exe_mem_wr_en;
    accept   = (state == IDLE) && exe_mem_valid;
`ifdef MEM_ALIGN_CHECK_EN
    misalign = is_mem && (exe_mem_reslt_data[1:0] != 2'b00);
`else
    misalign = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (exe_mem_valid && is_mem && !misalign) state_nxt = REQ;
      REQ:  if (dmem_mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The destination is held in mem_wb_reg_wr_add itself: it is written at
  // accept and cannot change again until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q             <= '0;
      wdata_q            <= '0;
      we_q               <= 1'b0;
      reg_wr_en_q        <= 1'b0;
      mem_wb_memory_data <= '0;
      mem_wb_reg_wr_data <= '0;
      mem_wb_reg_wr_en   <= 1'b0;
      mem_wb_rm_data_sel <= 1'b0;
      mem_wb_reg_wr_add  <= '0;
    end else begin
      mem_wb_reg_wr_en <= 1'b0;
      if (accept) begin
        mem_wb_reg_wr_data <= exe_mem_reslt_data;
        mem_wb_reg_wr_add  <= exe_mem_reg_wr_add;
        if (!is_mem) begin
          mem_wb_reg_wr_en   <= exe_mem_reg_wr_en;
          mem_wb_rm_data_sel <= 1'b0;
        end else if (!misalign) begin
          addr_q      <= exe_mem_reslt_data[31:2];
          wdata_q     <= exe_mem_store_data;
          we_q        <= is_store;
          // rd+wr together is a store, which never writes the register file
          reg_wr_en_q <= exe_mem_reg_wr_en & ~is_store;
        end
      end else if (state == REQ && dmem_mem_ack && !we_q) begin
        mem_wb_memory_data <= dmem_mem_rdata;
        mem_wb_rm_data_sel <= 1'b1;
        mem_wb_reg_wr_en   <= reg_wr_en_q;
      end
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  logic exc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exc_q <= 1'b0;
    else        exc_q <= accept && misalign;
  end
  assign mem_exc_misalign = exc_q;
`else
  assign mem_exc_misalign = 1'b0;
`endif

  assign mem_dmem_req   = (state == REQ);
  assign mem_dmem_we    = (state == REQ) && we_q;
  assign mem_dmem_addr  = {addr_q, 2'b00};
  assign mem_dmem_wdata = wdata_q;
  assign mem_stall      = (state == REQ);

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_mem_valid;
  logic [31:0] exe_mem_reslt_data;
  logic [31:0] exe_mem_store_data;
  logic        exe_mem_rd_en;
  logic        exe_mem_wr_en;
  logic        exe_mem_reg_wr_en;
  logic [4:0]  exe_mem_reg_wr_add;
  logic [31:0] dmem_mem_rdata;
  logic        dmem_mem_ack;
  logic        mem_dmem_req;
  logic        mem_dmem_we;
  logic [31:0] mem_dmem_addr;
  logic [31:0] mem_dmem_wdata;
  logic        mem_stall;
  logic        mem_exc_misalign;
  logic [31:0] mem_wb_memory_data;
  logic [31:0] mem_wb_reg_wr_data;
  logic        mem_wb_reg_wr_en;
  logic        mem_wb_rm_data_sel;
  logic [4:0]  mem_wb_reg_wr_add;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst_n(rst_n),
    .exe_mem_valid(exe_mem_valid), .exe_mem_reslt_data(exe_mem_reslt_data),
    .exe_mem_store_data(exe_mem_store_data), .exe_mem_rd_en(exe_mem_rd_en),
    .exe_mem_wr_en(exe_mem_wr_en), .exe_mem_reg_wr_en(exe_mem_reg_wr_en),
    .exe_mem_reg_wr_add(exe_mem_reg_wr_add), .dmem_mem_rdata(dmem_mem_rdata),
    .dmem_mem_ack(dmem_mem_ack), .mem_dmem_req(mem_dmem_req),
    .mem_dmem_we(mem_dmem_we), .mem_dmem_addr(mem_dmem_addr),
    .mem_dmem_wdata(mem_dmem_wdata), .mem_stall(mem_stall),
    .mem_exc_misalign(mem_exc_misalign), .mem_wb_memory_data(mem_wb_memory_data),
    .mem_wb_reg_wr_data(mem_wb_reg_wr_data), .mem_wb_reg_wr_en(mem_wb_reg_wr_en),
    .mem_wb_rm_data_sel(mem_wb_rm_data_sel), .mem_wb_reg_wr_add(mem_wb_reg_wr_add)
  );

  // Stimulus driver only; all checks are inline in the test tasks.
  task automatic drive(input logic v, input logic [31:0] res, input logic [31:0] sd,
                       input logic rd, input logic wr, input logic rwe, input logic [4:0] add);
    exe_mem_valid      = v;
    exe_mem_reslt_data = res;
    exe_mem_store_data = sd;
    exe_mem_rd_en      = rd;
    exe_mem_wr_en      = wr;
    exe_mem_reg_wr_en  = rwe;
    exe_mem_reg_wr_add = add;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    dmem_mem_rdata = 0;
    dmem_mem_ack   = 0;
    #3;
    checks++;
    if ({mem_dmem_req, mem_dmem_we, mem_stall, mem_exc_misalign, mem_wb_reg_wr_en, mem_wb_rm_data_sel} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 000000",
        {mem_dmem_req, mem_dmem_we, mem_stall, mem_exc_misalign, mem_wb_reg_wr_en, mem_wb_rm_data_sel});
    end
    checks++;
    if ({mem_dmem_addr, mem_dmem_wdata, mem_wb_memory_data, mem_wb_reg_wr_data, mem_wb_reg_wr_add} !== '0) begin
      failures++; $display("FAIL reset_data: got addr=%h wdata=%h md=%h wd=%h add=%0d expected all 0",
        mem_dmem_addr, mem_dmem_wdata, mem_wb_memory_data, mem_wb_reg_wr_data, mem_wb_reg_wr_add);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_alu_op();
    @(negedge clk);
    drive(1, 32'h0000_0010, 32'h0, 0, 0, 1, 5'd5);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({mem_wb_reg_wr_data, mem_wb_reg_wr_add, mem_wb_reg_wr_en, mem_wb_rm_data_sel} !== {32'h10, 5'd5, 1'b1, 1'b0}) begin
      failures++; $display("FAIL alu_wb: got wd=%h add=%0d en=%b sel=%b expected 10/5/1/0",
        mem_wb_reg_wr_data, mem_wb_reg_wr_add, mem_wb_reg_wr_en, mem_wb_rm_data_sel);
    end
    checks++;
    if (mem_dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      failures++; $display("FAIL alu_noreq: got req=%b stall=%b expected 0/0", mem_dmem_req, mem_stall);
    end
    @(negedge clk);
    checks++;
    if (mem_wb_reg_wr_en !== 1'b0 || mem_dmem_req !== 1'b0) begin
      failures++; $display("FAIL alu_bubble: got en=%b req=%b expected 0/0", mem_wb_reg_wr_en, mem_dmem_req);
    end
  endtask

  // Single load with ack on first REQ cycle.
  task automatic do_load(input string name, input logic [31:0] addr, input logic [31:0] exp_addr,
                         input logic [31:0] rdata, input logic [4:0] rd);
    @(negedge clk);
    drive(1, addr, 32'h0, 1, 0, 1, rd);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({mem_dmem_req, mem_dmem_we, mem_stall, mem_wb_reg_wr_en, mem_dmem_addr} !== {4'b1010, exp_addr}) begin
      failures++; $display("FAIL %s_req: got req=%b we=%b stall=%b en=%b addr=%h expected 1/0/1/0/%h",
        name, mem_dmem_req, mem_dmem_we, mem_stall, mem_wb_reg_wr_en, mem_dmem_addr, exp_addr);
    end
    dmem_mem_ack = 1; dmem_mem_rdata = rdata;
    @(negedge clk);
    dmem_mem_ack = 0; dmem_mem_rdata = 32'h0;
    checks++;
    if ({mem_wb_memory_data, mem_wb_rm_data_sel, mem_wb_reg_wr_en, mem_wb_reg_wr_add, mem_wb_reg_wr_data, mem_dmem_req, mem_stall}
        !== {rdata, 1'b1, 1'b1, rd, addr, 1'b0, 1'b0}) begin
      failures++; $display("FAIL %s_wb: got md=%h sel=%b en=%b add=%0d wd=%h req=%b stall=%b expected %h/1/1/%0d/%h/0/0",
        name, mem_wb_memory_data, mem_wb_rm_data_sel, mem_wb_reg_wr_en, mem_wb_reg_wr_add,
        mem_wb_reg_wr_data, mem_dmem_req, mem_stall, rdata, rd, addr);
    end
  endtask

  task automatic test_load();
    do_load("load", 32'h100, 32'h100, 32'hDEAD_BEEF, 5'd7);
  endtask

  task automatic test_store_wait();
    @(negedge clk);
    drive(1, 32'h200, 32'h1234_5678, 0, 1, 1, 5'd9);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_dmem_req, mem_dmem_we, mem_stall, mem_wb_reg_wr_en, mem_dmem_addr, mem_dmem_wdata}
          !== {4'b1110, 32'h200, 32'h1234_5678}) begin
        failures++; $display("FAIL store_wait%0d: got req=%b we=%b stall=%b en=%b addr=%h wdata=%h expected 1/1/1/0/200/12345678",
          i, mem_dmem_req, mem_dmem_we, mem_stall, mem_wb_reg_wr_en, mem_dmem_addr, mem_dmem_wdata);
      end
      dmem_mem_ack = (i == 3);
      @(negedge clk);
    end
    dmem_mem_ack = 0;
    checks++;
    if ({mem_dmem_req, mem_dmem_we, mem_stall, mem_wb_reg_wr_en, mem_wb_memory_data} !== {4'b0000, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL store_done: got req=%b we=%b stall=%b en=%b md=%h expected 0/0/0/0/deadbeef",
        mem_dmem_req, mem_dmem_we, mem_stall, mem_wb_reg_wr_en, mem_wb_memory_data);
    end
    // idle outputs hold last address/data
    checks++;
    if (mem_dmem_addr !== 32'h200 || mem_dmem_wdata !== 32'h1234_5678) begin
      failures++; $display("FAIL store_hold: got addr=%h wdata=%h expected 200/12345678", mem_dmem_addr, mem_dmem_wdata);
    end
  endtask

  task automatic test_spurious_ack();
    @(negedge clk);
    dmem_mem_ack = 1; dmem_mem_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    dmem_mem_ack = 0; dmem_mem_rdata = 0;
    checks++;
    if ({mem_dmem_req, mem_stall, mem_wb_reg_wr_en, mem_wb_memory_data} !== {3'b000, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL spurious_ack: got req=%b stall=%b en=%b md=%h expected 0/0/0/deadbeef",
        mem_dmem_req, mem_stall, mem_wb_reg_wr_en, mem_wb_memory_data);
    end
    do_load("spload", 32'h300, 32'h300, 32'hCAFE_F00D, 5'd3);
  endtask

  task automatic test_rd_wr_both();
    @(negedge clk);
    drive(1, 32'h340, 32'hA5A5_5A5A, 1, 1, 1, 5'd4);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_dmem_we !== 1'b1 || mem_dmem_req !== 1'b1) begin
      failures++; $display("FAIL both_we: got we=%b req=%b expected 1/1", mem_dmem_we, mem_dmem_req);
    end
    dmem_mem_ack = 1; dmem_mem_rdata = 32'h7777_7777;
    @(negedge clk);
    dmem_mem_ack = 0;
    checks++;
    if (mem_wb_reg_wr_en !== 1'b0 || mem_wb_memory_data !== 32'hCAFE_F00D) begin
      failures++; $display("FAIL both_nowr: got en=%b md=%h expected 0/cafef00d", mem_wb_reg_wr_en, mem_wb_memory_data);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1, 32'h500, 32'h0, 1, 0, 1, 5'd10);
    @(negedge clk);
    // next op presented while stalled; must wait for the ack
    drive(1, 32'h600, 32'h5555_AAAA, 0, 1, 0, 5'd11);
    dmem_mem_ack = 1; dmem_mem_rdata = 32'h1111_1111;
    @(negedge clk);
    dmem_mem_ack = 0;
    checks++;
    if ({mem_wb_memory_data, mem_wb_reg_wr_en, mem_wb_reg_wr_add, mem_dmem_req} !== {32'h1111_1111, 1'b1, 5'd10, 1'b0}) begin
      failures++; $display("FAIL b2b_first: got md=%h en=%b add=%0d req=%b expected 11111111/1/10/0",
        mem_wb_memory_data, mem_wb_reg_wr_en, mem_wb_reg_wr_add, mem_dmem_req);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({mem_dmem_req, mem_dmem_we, mem_dmem_addr, mem_dmem_wdata} !== {2'b11, 32'h600, 32'h5555_AAAA}) begin
      failures++; $display("FAIL b2b_second: got req=%b we=%b addr=%h wdata=%h expected 1/1/600/5555aaaa",
        mem_dmem_req, mem_dmem_we, mem_dmem_addr, mem_dmem_wdata);
    end
    dmem_mem_ack = 1;
    @(negedge clk);
    dmem_mem_ack = 0;
    checks++;
    if (mem_dmem_req !== 1'b0 || mem_wb_reg_wr_en !== 1'b0) begin
      failures++; $display("FAIL b2b_done: got req=%b en=%b expected 0/0", mem_dmem_req, mem_wb_reg_wr_en);
    end
  endtask

  task automatic test_reset_mid_req();
    @(negedge clk);
    drive(1, 32'h400, 32'h0, 1, 0, 1, 5'd2);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_dmem_req !== 1'b1) begin
      failures++; $display("FAIL rst_mid_pre: got req=%b expected 1", mem_dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_dmem_req, mem_dmem_we, mem_stall, mem_wb_reg_wr_en, mem_wb_rm_data_sel, mem_dmem_addr,
         mem_wb_memory_data, mem_wb_reg_wr_data, mem_wb_reg_wr_add} !== '0) begin
      failures++; $display("FAIL rst_mid: got req=%b stall=%b en=%b sel=%b addr=%h md=%h wd=%h expected all 0",
        mem_dmem_req, mem_stall, mem_wb_reg_wr_en, mem_wb_rm_data_sel, mem_dmem_addr,
        mem_wb_memory_data, mem_wb_reg_wr_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dmem_mem_ack = 1; dmem_mem_rdata = 32'h9999_9999;
    @(negedge clk);
    @(negedge clk);
    dmem_mem_ack = 0;
    checks++;
    if ({mem_dmem_req, mem_wb_reg_wr_en, mem_wb_rm_data_sel, mem_wb_memory_data} !== '0) begin
      failures++; $display("FAIL rst_late_ack: got req=%b en=%b sel=%b md=%h expected 0/0/0/0",
        mem_dmem_req, mem_wb_reg_wr_en, mem_wb_rm_data_sel, mem_wb_memory_data);
    end
  endtask

  task automatic test_misalign();
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    drive(1, 32'h102, 32'h0, 1, 0, 1, 5'd6);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if ({mem_exc_misalign, mem_dmem_req, mem_stall, mem_wb_reg_wr_en} !== 4'b1000) begin
      failures++; $display("FAIL misalign_exc: got exc=%b req=%b stall=%b en=%b expected 1/0/0/0",
        mem_exc_misalign, mem_dmem_req, mem_stall, mem_wb_reg_wr_en);
    end
    @(negedge clk);
    checks++;
    if (mem_exc_misalign !== 1'b0 || mem_dmem_req !== 1'b0) begin
      failures++; $display("FAIL misalign_pulse: got exc=%b req=%b expected 0/0", mem_exc_misalign, mem_dmem_req);
    end
`else
    do_load("unalign", 32'h102, 32'h100, 32'h2468_ACE0, 5'd6);
    checks++;
    if (mem_exc_misalign !== 1'b0) begin
      failures++; $display("FAIL unalign_exc: got %b expected 0", mem_exc_misalign);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store_wait();
    test_spurious_ack();
    test_rd_wr_both();
    test_back_to_back();
    test_reset_mid_req();
    test_misalign();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
